shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Command-driven controller wrapping a WIDTH-bit shift/rotate register. A requester issues a single command: load value, operation and step count. The block loads the register, applies one shift step per clock for the requested count, and signals completion. It replaces manual key-stepped load/rotate control with a sequenced, handshaked engine usable by upstream FSMs.

## Interface
- WIDTH, 8: register width in bits (≥2).
- CW, 4: width of count and steps_left; count range 0..2^CW−1.

- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command request; accepted only when ready=1.
- data_in  in  WIDTH  value loaded into register on accept.
- op  in  2  operation: 00 rotate right, 01 rotate left, 10 arithmetic shift right (MSB replicated), 11 logical shift left (LSB filled with 0).
- count  in  CW  number of shift steps to apply.
- hold  in  1  stalls shifting while high (SHIFT state only).
- ready  out  1  high in IDLE; command may be issued.
- done  out  1  one-cycle pulse when command completes.
- Q  out  WIDTH  current register contents.
- steps_left  out  CW  remaining steps of the active command.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: ready=1. On start=1, at the clock edge: Q←data_in, op and count latched, steps_left←count. Next state is SHIFT if count≠0, else DONE.
- SHIFT: ready=0. Each edge with hold=0 applies one step of the latched op to Q, and steps_left←steps_left−1. When steps_left=1 and hold=0, next state is DONE. With hold=1, Q, steps_left and state are unchanged.
- DONE: done=1, ready=0, Q holds the final value, steps_left=0. Next edge goes to IDLE.
- IDLE holds Q indefinitely. Outputs never change without a command.
- Op and count are latched at accept. Changes to op, count or data_in during SHIFT/DONE have no effect.
- start while ready=0 is ignored, not queued.
- count > WIDTH is legal:
  - rotates wrap modulo WIDTH;
  - ASR saturates to all-MSB;
  - LSL saturates to 0.
- hold in IDLE or DONE has no effect.
- Reset at any edge, including mid-SHIFT or in DONE, aborts the command: no done pulse.
- Reset values: state IDLE, ready=1, done=0, Q=0, steps_left=0. reset has priority over start.

## Timing
- Command accepted at edge k (start=1, ready=1 before edge k).
- Q=data_in after edge k.
- With count=n>0 and no hold: steps happen at edges k+1..k+n. done=1 during the cycle after edge k+n. ready=1 again after edge k+n+1. Accept-to-ready is n+2 cycles.
- With count=0: DONE after edge k, done=1 for that cycle, ready=1 after edge k+1.
- Each hold cycle in SHIFT extends all subsequent timing by one cycle.
- done is exactly one cycle wide. A new start may be accepted at the first edge where ready=1; back-to-back commands therefore have one IDLE cycle between done and next accept.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.

## Test plan
- Reset then idle:
  - Stimulus: reset=1 for 2 cycles, then release.
  - Required: ready=1, done=0, Q=8'h00, steps_left=0. Q stays 0 for 5 idle cycles.
- Rotate right:
  - Stimulus: data_in=8'b1000_0001, op=00, count=1.
  - Required: Q=8'b1000_0001 after the accept edge, Q=8'b1100_0000 one edge later, done pulses the following cycle.
- ASR and LSL:
  - ASR stimulus: data_in=8'h80, op=10, count=3. Required: final Q=8'hF0, done pulse 4 cycles after accept.
  - LSL stimulus: data_in=8'h81, op=11, count=9. Required: final Q=8'h00.
- Rotate-left wrap, ignored start and count=0:
  - Rotate-left stimulus: data_in=8'hA5, op=01, count=8. Required: final Q=8'hA5.
  - Stimulus: assert start mid-command with other data_in. Required: ignored; Q is unaffected.
  - count=0 stimulus: data_in=8'h3C. Required: done in the cycle after accept, Q=8'h3C.
- Hold:
  - Stimulus: data_in=8'h01, op=01, count=4, hold=1 for 3 cycles after the 2nd step.
  - Required: Q frozen at 8'h04 and steps_left=2 during hold. Final Q=8'h10. done delayed by exactly 3 cycles.
- Reset mid-operation:
  - Stimulus: op=00, count=6, reset asserted after 2 steps.
  - Required: Q=8'h00, ready=1, no done pulse. A new command afterwards completes normally.

Source files
------------

// File: rtl/shift_sequencer.sv
// Command-driven shift/rotate engine: loads a register, applies a latched
// operation one step per clock for a latched count, then pulses done.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       op,
    input  logic [CW-1:0]    count,
    input  logic             hold,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [CW-1:0]    steps_left
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_ROR = 2'b00;
    localparam logic [1:0] OP_ROL = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_LSL = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [1:0]       op_q, op_d;
    logic [CW-1:0]    steps_q, steps_d;

    // One step of the selected operation; ASR keeps the sign bit.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] val,
        input logic [1:0]       sel
    );
        logic signed [WIDTH-1:0] sval;
        sval = $signed(val);
        case (sel)
            OP_ROR:  shift_step = {val[0], val[WIDTH-1:1]};
            OP_ROL:  shift_step = {val[WIDTH-2:0], val[WIDTH-1]};
            OP_ASR:  shift_step = $unsigned(sval >>> 1);
            default: shift_step = {val[WIDTH-2:0], 1'b0};
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        op_d    = op_q;
        steps_d = steps_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    q_d     = data_in;
                    op_d    = op;
                    steps_d = count;
                    state_d = (count != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (!hold) begin
                    q_d     = shift_step(q_q, op_q);
                    steps_d = steps_q - 1'b1;
                    if (steps_q == CW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            op_q    <= OP_ROR;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            op_q    <= op_d;
            steps_q <= steps_d;
        end
    end

    // Outputs decode registered state only.
    assign ready      = (state_q == ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign Q          = q_q;
    assign steps_left = steps_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: vector table, directed corner
// sequences and randomized commands against a closed-form reference.
module tb_shift_sequencer;

    localparam int W = 8;
    localparam int C = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] data_in;
    logic [1:0]   op;
    logic [C-1:0] count;
    logic         hold;
    logic         ready;
    logic         done;
    logic [W-1:0] q;
    logic [C-1:0] steps_left;

    int checks = 0;
    int errors = 0;

    shift_sequencer #(.WIDTH(W), .CW(C)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .data_in    (data_in),
        .op         (op),
        .count      (count),
        .hold       (hold),
        .ready      (ready),
        .done       (done),
        .Q          (q),
        .steps_left (steps_left)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        logic [1:0] op;
        logic [3:0] cnt;
        logic [7:0] exp_q;
        int         lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Value of the register after j steps of operation o from d, from the
    // closed-form meaning of each operation.
    function automatic logic [7:0] ref_q(input logic [7:0] d, input logic [1:0] o, input int j);
        int x;
        int m;
        int r;
        x = int'(d);
        m = j % W;
        case (o)
            2'b00: r = (m == 0) ? x : (((x >> m) | (x << (W - m))) & 255);
            2'b01: r = (m == 0) ? x : (((x << m) | (x >> (W - m))) & 255);
            2'b10: begin
                if (j >= W) r = d[7] ? 255 : 0;
                else        r = (x >> j) | (d[7] ? (255 & ~(255 >> j)) : 0);
            end
            default: r = (j >= W) ? 0 : ((x << j) & 255);
        endcase
        return 8'(r);
    endfunction

    task automatic wait_ready();
        int w;
        w = 0;
        while (ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        chk("ready_before_cmd", 32'(ready), 32'd1);
    endtask

    task automatic run_cmd(input logic [7:0] d, input logic [1:0] o, input logic [3:0] n,
                           input logic [7:0] eq, input int lat, input bit noise);
        int cyc;
        wait_ready();
        start = 1'b1; data_in = d; op = o; count = n;
        tick();
        chk("load_q", 32'(q), 32'(d));
        chk("load_steps", 32'(steps_left), 32'(n));
        if (noise) begin
            start = 1'b1; data_in = ~d; op = ~o; count = ~n;
        end else begin
            start = 1'b0;
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", 32'(done), 32'd1);
        chk("latency", 32'(cyc), 32'(lat));
        chk("final_q", 32'(q), 32'(eq));
        chk("final_steps", 32'(steps_left), 32'd0);
        chk("ready_in_done", 32'(ready), 32'd0);
        tick();
        chk("done_width", 32'(done), 32'd0);
        chk("ready_after", 32'(ready), 32'd1);
        chk("q_held_idle", 32'(q), 32'(eq));
    endtask

    initial begin
        logic [7:0] d;
        logic [1:0] o;
        logic [3:0] n;
        int         j;
        int         guard;
        int         cyc;

        vecs[0] = '{8'h81, 2'b00, 4'd1,  8'hC0, 1};
        vecs[1] = '{8'h80, 2'b10, 4'd3,  8'hF0, 3};
        vecs[2] = '{8'h81, 2'b11, 4'd9,  8'h00, 9};
        vecs[3] = '{8'hA5, 2'b01, 4'd8,  8'hA5, 8};
        vecs[4] = '{8'h3C, 2'b00, 4'd0,  8'h3C, 0};
        vecs[5] = '{8'hF0, 2'b00, 4'd12, 8'h0F, 12};
        vecs[6] = '{8'h7F, 2'b10, 4'd10, 8'h00, 10};
        vecs[7] = '{8'h11, 2'b11, 4'd5,  8'h20, 5};

        reset = 1'b1; start = 1'b0; hold = 1'b0;
        data_in = '0; op = '0; count = '0;

        // Reset then idle
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_steps", 32'(steps_left), 32'd0);
        for (int i = 0; i < 5; i++) begin
            data_in = 8'(8'hE7 + i); hold = 1'(i);
            tick();
            chk("idle_q", 32'(q), 32'd0);
            chk("idle_ready", 32'(ready), 32'd1);
        end
        hold = 1'b0;

        // Table of commands; odd entries drive a conflicting start mid-command
        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].data, vecs[i].op, vecs[i].cnt, vecs[i].exp_q, vecs[i].lat, i[0]);
        end

        // Hold after the second step for three cycles
        wait_ready();
        start = 1'b1; data_in = 8'h01; op = 2'b01; count = 4'd4;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("hold_pre_q", 32'(q), 32'h04);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_q", 32'(q), 32'h04);
            chk("hold_steps", 32'(steps_left), 32'd2);
            chk("hold_done", 32'(done), 32'd0);
        end
        hold = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("hold_latency", 32'(cyc), 32'd2);
        chk("hold_final_q", 32'(q), 32'h10);
        tick();
        chk("hold_ready_after", 32'(ready), 32'd1);

        // Reset mid-operation, with start asserted alongside reset
        wait_ready();
        start = 1'b1; data_in = 8'h96; op = 2'b00; count = 4'd6;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre_rst_q", 32'(q), 32'(ref_q(8'h96, 2'b00, 2)));
        reset = 1'b1; start = 1'b1; data_in = 8'h55; count = 4'd2;
        tick();
        reset = 1'b0; start = 1'b0;
        chk("abort_q", 32'(q), 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_steps", 32'(steps_left), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_done", 32'(done), 32'd0);
        end
        run_cmd(8'hC3, 2'b00, 4'd2, 8'hF0, 2, 1'b0);

        // Randomized commands with random hold and ignored starts
        for (int t = 0; t < 40; t++) begin
            d = 8'($urandom);
            o = 2'($urandom);
            n = 4'($urandom);
            wait_ready();
            hold = 1'($urandom);
            start = 1'b1; data_in = d; op = o; count = n;
            tick();
            start = 1'b0;
            j = 0;
            chk("rnd_load_q", 32'(q), 32'(ref_q(d, o, 0)));
            chk("rnd_load_steps", 32'(steps_left), 32'(n));
            chk("rnd_load_done", 32'(done), 32'(n == 0));
            guard = 0;
            while (j < int'(n) && guard < 100) begin
                hold = ($urandom_range(0, 3) == 0);
                start = 1'($urandom);
                data_in = 8'($urandom);
                op = 2'($urandom);
                count = 4'($urandom);
                tick();
                guard++;
                if (!hold) j++;
                chk("rnd_q", 32'(q), 32'(ref_q(d, o, j)));
                chk("rnd_steps", 32'(steps_left), 32'(int'(n) - j));
                chk("rnd_done", 32'(done), 32'(j == int'(n)));
                chk("rnd_ready", 32'(ready), 32'd0);
            end
            start = 1'b0;
            hold = 1'($urandom);
            tick();
            chk("rnd_ready_after", 32'(ready), 32'd1);
            chk("rnd_done_after", 32'(done), 32'd0);
            chk("rnd_final_q", 32'(q), 32'(ref_q(d, o, int'(n))));
            hold = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
